// File: rtl/cmp_serial_pkg.sv
// Shared types and helpers for the bit-serial comparator.
//   cmp_op_e  : relational op encoding (6 and 7 are reserved and yield 0)
//   state_e   : controller states
//   num_passes: cycles needed to sweep a WIDTH-bit operand DIGIT bits at a time
//   cnt_width : pass-counter width, never below 1 bit
package cmp_serial_pkg;

  typedef enum logic [2:0] {
    CMP_LT = 3'd0,
    CMP_LE = 3'd1,
    CMP_GT = 3'd2,
    CMP_GE = 3'd3,
    CMP_EQ = 3'd4,
    CMP_NE = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned num_passes(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_digit_cmp.sv
// One DIGIT-bit slice of the serial subtract-with-borrow chain.
//   a_i, b_i     : operand slices
//   borrow_i     : borrow from less-significant slices
//   borrow_o     : borrow out of (a - b - borrow_i)
//   slice_eq_o   : slices are bit-identical
module sub_digit_cmp #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             borrow_i,
  output logic             borrow_o,
  output logic             slice_eq_o
);

  // a - b - bin underflows exactly when a < b, or a == b with an incoming borrow.
  always_comb begin
    slice_eq_o = (a_i == b_i);
    borrow_o   = (a_i < b_i) || (slice_eq_o && borrow_i);
  end

endmodule

// File: rtl/cmp_serial_nbit.sv
// Sequential WIDTH-bit comparator: LSB-first, DIGIT bits per cycle, through a
// borrow/equality chain. Valid/ready handshake on input and output.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (ready only while idle)
//   A, B, op, is_signed : operands, relational op, signedness
//   out_valid, out_ready: result handshake (result held until taken)
//   Y                   : registered result of (A op B)
//   Z                   : only with CMP_SERIAL_MINMAX_EN defined; Y ? A : B
module cmp_serial_nbit
  import cmp_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y
`ifdef CMP_SERIAL_MINMAX_EN
  ,
  output logic [WIDTH-1:0] Z
`endif
);

  localparam int unsigned N    = num_passes(WIDTH, DIGIT);
  localparam int unsigned CntW = cnt_width(N);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("cmp_serial_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  cmp_op_e           op_q;
  logic              signed_q;
  logic              borrow_q, eq_q;
  logic [CntW-1:0]   cnt_q;
  logic              y_q;

  logic              borrow_nxt, slice_eq, eq_nxt, lt, y_nxt, last_pass;
  logic              a_sign, b_sign;

  sub_digit_cmp #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_i       (a_q[DIGIT-1:0]),
    .b_i       (b_q[DIGIT-1:0]),
    .borrow_i  (borrow_q),
    .borrow_o  (borrow_nxt),
    .slice_eq_o(slice_eq)
  );

  assign last_pass = (cnt_q == CntW'(N - 1));

  // On the last pass the low slice holds the original MSB digit, so the sign
  // bits are read from there.
  always_comb begin
    eq_nxt = eq_q & slice_eq;
    a_sign = a_q[DIGIT-1];
    b_sign = b_q[DIGIT-1];
    lt     = (signed_q && (a_sign != b_sign)) ? a_sign : borrow_nxt;
    case (op_q)
      CMP_LT:  y_nxt = lt;
      CMP_LE:  y_nxt = lt | eq_nxt;
      CMP_GT:  y_nxt = ~(lt | eq_nxt);
      CMP_GE:  y_nxt = ~lt;
      CMP_EQ:  y_nxt = eq_nxt;
      CMP_NE:  y_nxt = ~eq_nxt;
      default: y_nxt = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_pass) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state only
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Datapath. Operands rotate right each pass; after N passes they are back
  // in their original positions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= CMP_LT;
      signed_q <= 1'b0;
      borrow_q <= 1'b0;
      eq_q     <= 1'b1;
      cnt_q    <= '0;
      y_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= cmp_op_e'(op);
            signed_q <= is_signed;
            borrow_q <= 1'b0;
            eq_q     <= 1'b1;
            cnt_q    <= '0;
          end
        end
        StRun: begin
          borrow_q <= borrow_nxt;
          eq_q     <= eq_nxt;
          a_q      <= (a_q >> DIGIT) | (a_q << (WIDTH - DIGIT));
          b_q      <= (b_q >> DIGIT) | (b_q << (WIDTH - DIGIT));
          cnt_q    <= cnt_q + CntW'(1);
          if (last_pass) y_q <= y_nxt;
        end
        default: ;
      endcase
    end
  end

  assign Y = y_q;

`ifdef CMP_SERIAL_MINMAX_EN
  assign Z = out_valid ? (y_q ? a_q : b_q) : '0;
`endif

endmodule
